// File: rtl/rps4_pkg.sv
// rps4_pkg: shared definitions for the four-requester rotating-priority
// selector (rps_4) and its 2-input priority leaf (rps_2).
//   NUM_REQ : number of requesters (fixed at 4)
//   CNT_W   : width of the free-running priority counter
//   req_t   : request / grant vector type
//   cnt_t   : priority counter type
package rps4_pkg;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 2;

  typedef logic [NUM_REQ-1:0] req_t;
  typedef logic [CNT_W-1:0]   cnt_t;

endpackage

// File: rtl/rps_2.sv
// rps_2: 2-input combinational priority selector, the building block of the
// rps_4 priority tree.
// Ports:
//   req    in  [1:0] request pair
//   en     in        grant enable; 0 forces gnt to 00
//   sel    in        1 prefers bit 1, 0 prefers bit 0
//   gnt    out [1:0] one-hot-or-zero grant
//   req_up out       OR of req, tells the parent this pair has work
module rps_2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       sel,
  output logic [1:0] gnt,
  output logic       req_up
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (sel) begin
        gnt[1] = req[1];
        gnt[0] = req[0] & ~req[1];
      end else begin
        gnt[0] = req[0];
        gnt[1] = req[1] & ~req[0];
      end
    end
  end

  // req_up is independent of en so the parent can decide before enabling.
  assign req_up = req[1] | req[0];

endmodule

// File: rtl/rps_4.sv
// rps_4: four-requester rotating-priority selector with a built-in
// free-running 2-bit priority counter. Each cycle at most one request is
// granted; priority rotates with the counter.
// Ports:
//   clock in        sole clock, rising edge
//   reset in        synchronous active-high, clears the counter
//   req   in  [3:0] request vector, bit i = requester i
//   en    in        grant enable; 0 forces gnt to zero
//   gnt   out [3:0] one-hot-or-zero grant, combinational
//   count out [1:0] current priority counter (exposed state)
// Handshake: level based, no storage. A requester holds req[i] high while it
// wants the resource; it owns the resource in any cycle where gnt[i] is high.
// Nothing is queued, so a request not granted this cycle must stay asserted.
// Optional macro RPS4_ASSERT_EN: compiles in simulation assertions.
module rps_4
  import rps4_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  req_t req,
  input  logic en,
  output req_t gnt,
  output cnt_t count
);

  logic [1:0] root_req;
  logic [1:0] root_gnt;
  logic       root_up;

  // Counter runs every edge, independent of en and req.
  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else       count <= count + cnt_t'(1);
  end

  // Leaves pick the preferred bit inside each pair (count[0] = odd first).
  rps_2 u_leaf_lo (
    .req    (req[1:0]),
    .en     (root_gnt[0]),
    .sel    (count[0]),
    .gnt    (gnt[1:0]),
    .req_up (root_req[0])
  );

  rps_2 u_leaf_hi (
    .req    (req[3:2]),
    .en     (root_gnt[1]),
    .sel    (count[0]),
    .gnt    (gnt[3:2]),
    .req_up (root_req[1])
  );

  // Root picks the pair (count[1] = upper pair first); its one-hot grant
  // enables exactly one leaf, which keeps gnt one-hot.
  rps_2 u_root (
    .req    (root_req),
    .en     (en),
    .sel    (count[1]),
    .gnt    (root_gnt),
    .req_up (root_up)
  );

`ifdef RPS4_ASSERT_EN
  cnt_t last_count;
  logic last_ok;
  logic seen_reset;

  always_ff @(posedge clock) begin
    seen_reset <= seen_reset | reset;
    last_ok    <= ~reset & (seen_reset | reset);
    last_count <= count;
    if (!reset) begin
      assert ($onehot0(gnt)) else $error("gnt not one-hot-or-zero: %b", gnt);
      assert ((gnt & ~req) == '0) else $error("gnt %b outside req %b", gnt, req);
      assert (en || gnt == '0) else $error("gnt %b while en=0", gnt);
      assert (!(en && root_up) || gnt != '0) else $error("no grant for req %b", req);
      if (last_ok)
        assert (count == last_count + cnt_t'(1))
          else $error("count %0d did not follow %0d", count, last_count);
    end
  end
`else
  logic unused_root_up;
  assign unused_root_up = root_up;
`endif

endmodule

// File: tb/tb_rps_4.sv
// tb_rps_4: self-checking bench for rps_4. Directed table vectors, a few
// multi-cycle sequences (reset, en=0, mid-run reset) and randomized cycles
// checked against a priority-order reference model.
module tb_rps_4;
  import rps4_pkg::*;

  logic clock;
  logic reset;
  req_t req;
  logic en;
  req_t gnt;
  cnt_t count;

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;

  rps_4 dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .en    (en),
    .gnt   (gnt),
    .count (count)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model ----------------
  // Priority orders written straight from the rotation table.
  int order [4][4] = '{'{0, 1, 2, 3}, '{1, 0, 3, 2}, '{2, 3, 0, 1}, '{3, 2, 1, 0}};

  function automatic req_t ref_gnt(int cnt, req_t r, logic e);
    if (!e) return '0;
    for (int k = 0; k < 4; k++) begin
      if (r[order[cnt][k]]) return req_t'(1 << order[cnt][k]);
    end
    return '0;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock edge; model counter follows the reset value present at the edge.
  task automatic tick();
    @(posedge clock);
    model_cnt = reset ? 0 : (model_cnt + 1) % 4;
    #1;
  endtask

  task automatic goto_count(input int c);
    for (int i = 0; i < 4 && model_cnt != c; i++) tick();
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard-style vector table ----------------
  typedef struct {
    int   cnt;
    req_t req;
    logic en;
    req_t exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0, 4'b0001, 1'b1, 4'b0001};
    vecs[1]  = '{1, 4'b0010, 1'b1, 4'b0010};
    vecs[2]  = '{2, 4'b0101, 1'b1, 4'b0100};
    vecs[3]  = '{3, 4'b0011, 1'b1, 4'b0010};
    vecs[4]  = '{0, 4'b1010, 1'b1, 4'b0010};
    vecs[5]  = '{1, 4'b1100, 1'b1, 4'b1000};
    vecs[6]  = '{2, 4'b0000, 1'b1, 4'b0000};
    vecs[7]  = '{3, 4'b0000, 1'b1, 4'b0000};
    vecs[8]  = '{0, 4'b0000, 1'b1, 4'b0000};
    vecs[9]  = '{1, 4'b0000, 1'b1, 4'b0000};
    vecs[10] = '{2, 4'b1111, 1'b0, 4'b0000};
    vecs[11] = '{3, 4'b1010, 1'b0, 4'b0000};

    reset = 1'b1;
    en    = 1'b1;
    req   = 4'b1111;

    // Reset held one edge, then count walks 0,1,2,3,0 with all requesting.
    tick();
    reset = 1'b0;
    #1;
    check("reset_count", {2'b00, count}, 4'd0);
    check("reset_gnt", gnt, 4'b0001);
    begin
      req_t walk_exp[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] cnt_exp[4] = '{4'd1, 4'd2, 4'd3, 4'd0};
      for (int i = 0; i < 4; i++) begin
        tick();
        check("walk_count", {2'b00, count}, cnt_exp[i]);
        check("walk_gnt", gnt, walk_exp[i]);
      end
    end

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      goto_count(vecs[i].cnt);
      req = vecs[i].req;
      en  = vecs[i].en;
      #1;
      check("vec_count", {2'b00, count}, 4'(vecs[i].cnt));
      check($sformatf("vec%0d_gnt", i), gnt, vecs[i].exp);
      tick();
    end

    // en=0 over two edges: no grant, counter keeps going.
    goto_count(0);
    en  = 1'b0;
    req = 4'b1111;
    #1;
    check("en0_gnt_a", gnt, 4'b0000);
    check("en0_count_a", {2'b00, count}, 4'd0);
    tick();
    check("en0_gnt_b", gnt, 4'b0000);
    check("en0_count_b", {2'b00, count}, 4'd1);

    // Reset asserted at count=2 takes priority over increment.
    en = 1'b1;
    goto_count(2);
    check("pre_rst_count", {2'b00, count}, 4'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_count", {2'b00, count}, 4'd0);
    check("mid_rst_gnt", gnt, 4'b0001);

    // Randomized cycles against the reference model.
    for (int i = 0; i < 300; i++) begin
      req   = req_t'($urandom_range(0, 15));
      en    = ($urandom_range(0, 7) != 0);
      reset = ($urandom_range(0, 15) == 0);
      #1;
      check("rnd_count", {2'b00, count}, 4'(model_cnt));
      check("rnd_gnt", gnt, ref_gnt(model_cnt, req, en));
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
